// File: rtl/gate_sweep_pkg.sv
// Shared encodings for the exhaustive gate sweep checker:
// golden-function select codes and the sweep FSM state type.
package gate_sweep_pkg;

    localparam logic [1:0] MODE_AND  = 2'b00;
    localparam logic [1:0] MODE_OR   = 2'b01;
    localparam logic [1:0] MODE_XOR  = 2'b10;
    localparam logic [1:0] MODE_NAND = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_SETTLE = 2'b01,
        ST_CHECK  = 2'b10,
        ST_DONE   = 2'b11
    } state_e;

endpackage

// File: rtl/gate_sweep_checker_if.sv
// Control, result and DUT-facing signals of the gate sweep checker.
// The slave modport is the checker; the master modport is the host plus gate under test.
interface gate_sweep_checker_if #(
    parameter int N_IN  = 3,
    parameter int ERR_W = 8
);
    logic              start;
    logic [1:0]        mode;
    logic [N_IN-1:0]   dut_in;
    logic              dut_y;
    logic              busy;
    logic              done;
    logic              pass;
    logic [ERR_W-1:0]  err_count;
    logic [N_IN-1:0]   first_fail_vec;
    logic              first_fail_valid;

    modport master (
        output start, mode, dut_y,
        input  dut_in, busy, done, pass, err_count, first_fail_vec, first_fail_valid
    );

    modport slave (
        input  start, mode, dut_y,
        output dut_in, busy, done, pass, err_count, first_fail_vec, first_fail_valid
    );
endinterface

// File: rtl/gate_ref_model.sv
// Golden combinational model of the N-input gate under test,
// selected by the 2-bit function code.
module gate_ref_model
    import gate_sweep_pkg::*;
#(
    parameter int N_IN = 3
) (
    input  logic [N_IN-1:0] vec,
    input  logic [1:0]      mode,
    output logic            expected
);

    // Reduction selected by the function code
    always_comb begin
        expected = 1'b0;
        case (mode)
            MODE_AND:  expected = &vec;
            MODE_OR:   expected = |vec;
            MODE_XOR:  expected = ^vec;
            MODE_NAND: expected = ~&vec;
            default:   expected = 1'b0;
        endcase
    end

endmodule

// File: rtl/gate_sweep_checker.sv
// Exhaustive sweep of all 2^N_IN input vectors of a combinational gate,
// comparing its output against the golden model after a settle delay.
module gate_sweep_checker
    import gate_sweep_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int SETTLE = 2,
    parameter int ERR_W  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    gate_sweep_checker_if.slave  bus
);

    localparam int               CNT_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);
    localparam logic [N_IN-1:0]  VEC_LAST = {N_IN{1'b1}};
    localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};

    state_e            state_r;
    state_e            state_s;
    logic [N_IN-1:0]   vec_r;
    logic [CNT_W-1:0]  cnt_r;
    logic [1:0]        mode_r;
    logic              busy_r;
    logic              done_r;
    logic              pass_r;
    logic [ERR_W-1:0]  err_count_r;
    logic [N_IN-1:0]   first_fail_vec_r;
    logic              first_fail_valid_r;
    logic              expected_s;
    logic              mismatch_s;
    logic              last_vec_s;

    gate_ref_model #(.N_IN(N_IN)) u_ref (
        .vec      (vec_r),
        .mode     (mode_r),
        .expected (expected_s)
    );

    assign mismatch_s = (bus.dut_y != expected_s);
    // Explicit compare so the counter never wraps back to vector zero
    assign last_vec_s = (vec_r == VEC_LAST);

    assign bus.dut_in           = vec_r;
    assign bus.busy             = busy_r;
    assign bus.done             = done_r;
    assign bus.pass             = pass_r;
    assign bus.err_count        = err_count_r;
    assign bus.first_fail_vec   = first_fail_vec_r;
    assign bus.first_fail_valid = first_fail_valid_r;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) state_s = ST_SETTLE;
                else           state_s = ST_IDLE;
            end
            ST_SETTLE: begin
                if (cnt_r == CNT_LAST) state_s = ST_CHECK;
                else                   state_s = ST_SETTLE;
            end
            ST_CHECK: begin
                if (last_vec_s) state_s = ST_DONE;
                else            state_s = ST_SETTLE;
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Sweep datapath and registered result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_r              <= {N_IN{1'b0}};
            cnt_r              <= {CNT_W{1'b0}};
            mode_r             <= MODE_AND;
            busy_r             <= 1'b0;
            done_r             <= 1'b0;
            pass_r             <= 1'b0;
            err_count_r        <= {ERR_W{1'b0}};
            first_fail_vec_r   <= {N_IN{1'b0}};
            first_fail_valid_r <= 1'b0;
        end else begin
            busy_r <= (state_s != ST_IDLE);
            done_r <= (state_s == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        mode_r             <= bus.mode;
                        vec_r              <= {N_IN{1'b0}};
                        cnt_r              <= {CNT_W{1'b0}};
                        err_count_r        <= {ERR_W{1'b0}};
                        first_fail_vec_r   <= {N_IN{1'b0}};
                        first_fail_valid_r <= 1'b0;
                        pass_r             <= 1'b0;
                    end
                end
                ST_SETTLE: cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                ST_CHECK: begin
                    if (mismatch_s) begin
                        if (err_count_r != ERR_MAX) begin
                            err_count_r <= err_count_r + {{(ERR_W-1){1'b0}}, 1'b1};
                        end
                        if (!first_fail_valid_r) begin
                            first_fail_vec_r   <= vec_r;
                            first_fail_valid_r <= 1'b1;
                        end
                    end
                    if (!last_vec_s) begin
                        vec_r <= vec_r + {{(N_IN-1){1'b0}}, 1'b1};
                        cnt_r <= {CNT_W{1'b0}};
                    end
                end
                ST_DONE: pass_r <= (err_count_r == {ERR_W{1'b0}});
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench for gate_sweep_checker: 3-input sweeps against a good AND gate,
// a stuck-at-0 gate, a saturating 2-bit error counter, restarts and mid-sweep reset.
module tb_gate_sweep_checker;
    import gate_sweep_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic stuck_a = 1'b0;
    logic and_y_s;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;

    gate_sweep_checker_if #(.N_IN(3), .ERR_W(8)) bus_a ();
    gate_sweep_checker_if #(.N_IN(3), .ERR_W(2)) bus_b ();

    gate_sweep_checker #(.N_IN(3), .SETTLE(2), .ERR_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .bus(bus_a));
    gate_sweep_checker #(.N_IN(3), .SETTLE(2), .ERR_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .bus(bus_b));

    // Gate under test for instance A: a good AND, or stuck at 0
    gate_ref_model #(.N_IN(3)) u_good_and (
        .vec(bus_a.dut_in), .mode(MODE_AND), .expected(and_y_s));
    assign bus_a.dut_y = stuck_a ? 1'b0 : and_y_s;
    assign bus_b.dut_y = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] cur_dut_in(input bit sel);
        return sel ? bus_b.dut_in : bus_a.dut_in;
    endfunction

    function automatic logic cur_done(input bit sel);
        return sel ? bus_b.done : bus_a.done;
    endfunction

    task automatic drive_start(input bit sel, input logic v, input logic [1:0] m);
        if (sel) begin
            bus_b.start = v;
            bus_b.mode  = m;
        end else begin
            bus_a.start = v;
            bus_a.mode  = m;
        end
    endtask

    // Raise start, let one edge sample it; optionally keep start high afterwards
    task automatic start_sweep(input bit sel, input logic [1:0] m, input bit hold);
        drive_start(sel, 1'b1, m);
        @(posedge clk); #1;
        if (!hold) drive_start(sel, 1'b0, m);
    endtask

    // Called just after the start-sampling edge; returns the edge index of done
    task automatic run_sweep(input bit sel, input bit disturb,
                             output int done_edge, output int trace_bad);
        done_edge = -1;
        trace_bad = 0;
        if (cur_dut_in(sel) !== 3'd0) trace_bad++;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            if (disturb && k == 6) drive_start(sel, 1'b1, MODE_OR);
            if (disturb && k == 7) drive_start(sel, 1'b0, MODE_OR);
            if (k < 24 && cur_dut_in(sel) !== 3'(k / 3)) trace_bad++;
            if (cur_done(sel)) begin
                done_edge = k;
                break;
            end
        end
    endtask

    task automatic check_results_a(input string pfx, input int e_err, input int e_vec,
                                   input logic e_valid, input logic e_pass);
        check_eq({pfx, "_done_pulse"}, 32'(bus_a.done), 32'd0);
        check_eq({pfx, "_busy"},       32'(bus_a.busy), 32'd0);
        check_eq({pfx, "_pass"},       32'(bus_a.pass), 32'(e_pass));
        check_eq({pfx, "_err"},        32'(bus_a.err_count), 32'(e_err));
        check_eq({pfx, "_ffvec"},      32'(bus_a.first_fail_vec), 32'(e_vec));
        check_eq({pfx, "_ffvalid"},    32'(bus_a.first_fail_valid), 32'(e_valid));
    endtask

    initial begin
        int done_edge;
        int trace_bad;
        int seen_done;
        drive_start(1'b0, 1'b0, MODE_AND);
        drive_start(1'b1, 1'b0, MODE_AND);

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_dut_in", 32'(bus_a.dut_in), 32'd0);
        check_eq("rst_busy",   32'(bus_a.busy), 32'd0);
        check_eq("rst_done",   32'(bus_a.done), 32'd0);
        check_eq("rst_pass",   32'(bus_a.pass), 32'd0);
        check_eq("rst_err",    32'(bus_a.err_count), 32'd0);
        check_eq("rst_ffvalid", 32'(bus_a.first_fail_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 1: good AND gate, AND mode
        start_sweep(1'b0, MODE_AND, 1'b0);
        check_eq("s1_busy_after_start", 32'(bus_a.busy), 32'd1);
        run_sweep(1'b0, 1'b0, done_edge, trace_bad);
        check_eq("s1_done_edge", 32'(done_edge), 32'd24);
        check_eq("s1_trace", 32'(trace_bad), 32'd0);
        @(posedge clk); #1;
        check_results_a("s1", 0, 0, 1'b0, 1'b1);

        // 2: stuck-at-0 gate, AND mode
        stuck_a = 1'b1;
        start_sweep(1'b0, MODE_AND, 1'b0);
        run_sweep(1'b0, 1'b0, done_edge, trace_bad);
        check_eq("s2_done_edge", 32'(done_edge), 32'd24);
        @(posedge clk); #1;
        check_results_a("s2", 1, 7, 1'b1, 1'b0);
        stuck_a = 1'b0;

        // 3: good AND gate checked against OR
        start_sweep(1'b0, MODE_OR, 1'b0);
        run_sweep(1'b0, 1'b0, done_edge, trace_bad);
        check_eq("s3_done_edge", 32'(done_edge), 32'd24);
        @(posedge clk); #1;
        check_results_a("s3", 6, 1, 1'b1, 1'b0);

        // 4: 2-bit saturating counter, XOR mode, gate output 0
        start_sweep(1'b1, MODE_XOR, 1'b0);
        run_sweep(1'b1, 1'b0, done_edge, trace_bad);
        check_eq("s4_done_edge", 32'(done_edge), 32'd24);
        check_eq("s4_trace", 32'(trace_bad), 32'd0);
        @(posedge clk); #1;
        check_eq("s4_err_sat", 32'(bus_b.err_count), 32'd3);
        check_eq("s4_ffvec",   32'(bus_b.first_fail_vec), 32'd1);
        check_eq("s4_ffvalid", 32'(bus_b.first_fail_valid), 32'd1);
        check_eq("s4_pass",    32'(bus_b.pass), 32'd0);

        // 5a: start pulse and mode change mid-sweep are ignored
        start_sweep(1'b0, MODE_AND, 1'b0);
        run_sweep(1'b0, 1'b1, done_edge, trace_bad);
        check_eq("s5a_done_edge", 32'(done_edge), 32'd24);
        check_eq("s5a_trace", 32'(trace_bad), 32'd0);
        @(posedge clk); #1;
        check_results_a("s5a", 0, 0, 1'b0, 1'b1);

        // 5b: start held through DONE launches a second sweep
        start_sweep(1'b0, MODE_AND, 1'b1);
        run_sweep(1'b0, 1'b0, done_edge, trace_bad);
        check_eq("s5b_done_edge1", 32'(done_edge), 32'd24);
        @(posedge clk); #1;
        check_eq("s5b_idle_busy", 32'(bus_a.busy), 32'd0);
        check_eq("s5b_idle_pass", 32'(bus_a.pass), 32'd1);
        @(posedge clk); #1;
        drive_start(1'b0, 1'b0, MODE_AND);
        check_eq("s5b_restart_busy", 32'(bus_a.busy), 32'd1);
        check_eq("s5b_restart_pass_clr", 32'(bus_a.pass), 32'd0);
        run_sweep(1'b0, 1'b0, done_edge, trace_bad);
        check_eq("s5b_done_edge2", 32'(done_edge), 32'd24);
        check_eq("s5b_trace2", 32'(trace_bad), 32'd0);
        @(posedge clk); #1;
        check_results_a("s5b", 0, 0, 1'b0, 1'b1);

        // 6: asynchronous reset while vector 4 is on the gate
        start_sweep(1'b0, MODE_OR, 1'b0);
        for (int k = 0; k < 50; k++) begin
            if (bus_a.dut_in == 3'd4) break;
            @(posedge clk); #1;
        end
        check_eq("s6_at_vec4", 32'(bus_a.dut_in), 32'd4);
        check_eq("s6_err_before", 32'(bus_a.err_count), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("s6_async_dut_in",  32'(bus_a.dut_in), 32'd0);
        check_eq("s6_async_busy",    32'(bus_a.busy), 32'd0);
        check_eq("s6_async_err",     32'(bus_a.err_count), 32'd0);
        check_eq("s6_async_ffvec",   32'(bus_a.first_fail_vec), 32'd0);
        check_eq("s6_async_ffvalid", 32'(bus_a.first_fail_valid), 32'd0);
        seen_done = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus_a.done) seen_done++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        if (bus_a.done) seen_done++;
        check_eq("s6_no_done", 32'(seen_done), 32'd0);
        start_sweep(1'b0, MODE_AND, 1'b0);
        run_sweep(1'b0, 1'b0, done_edge, trace_bad);
        check_eq("s6_done_edge", 32'(done_edge), 32'd24);
        check_eq("s6_trace", 32'(trace_bad), 32'd0);
        @(posedge clk); #1;
        check_results_a("s6", 0, 0, 1'b0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
